gray_sobel: RTL and testbench
=============================

GRAY_SOBEL -- requirements
Module: gray_sobel

Interface
REQ-001 The block SHALL have parameter W, default 317, meaning image width in pixels.
REQ-002 The block SHALL have parameter H, default 391, meaning image height in pixels.
REQ-003 The block SHALL have parameter THRESH, default 100, meaning the edge threshold (used only under SOBEL_THRESH_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_pixel carries a grayscale pixel this cycle.
REQ-007 The block SHALL have port in_pixel, input, 8 bits: grayscale pixel, raster order, row-major.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_pixel holds a valid edge pixel.
REQ-009 The block SHALL have port out_pixel, output, 8 bits: edge magnitude, or binary edge under SOBEL_THRESH_EN.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse coinciding with the last output of a frame.

Function
REQ-011 The block SHALL accept one pixel per cycle with in_valid=1 and apply no backpressure; cycles with in_valid=0 SHALL leave all internal state unchanged.
REQ-012 The block SHALL track input position with col (0..W-1) and row (0..H-1) counters, advancing col per accepted pixel and advancing row and clearing col at col=W-1.
REQ-013 On acceptance of pixel (H-1, W-1), both counters SHALL wrap to 0 and the next accepted pixel SHALL begin a new frame.
REQ-014 The block SHALL keep two W-deep line buffers (rows r-1, r-2) plus two registered columns, forming a 3x3 window p[i][j] (i=row 0..2 oldest to newest, j=col 0..2 oldest to newest).
REQ-015 The block SHALL run a two-state machine: FILL while row<2 (no output) and RUN while row>=2; FILL SHALL move to RUN on the wrap from row 1 to row 2, and RUN SHALL return to FILL on frame wrap.
REQ-016 In RUN, an accepted pixel at (r,c) with c>=2 SHALL cause out_valid=1 in the next cycle only, with out_pixel for centre (r-1,c-1); border pixels SHALL produce no output, giving (H-2)*(W-2) outputs per frame.
REQ-017 The block SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02) as 11-bit signed values with no overflow.
REQ-018 The block SHALL compute magnitude=|Gx|+|Gy| (0..2040) and saturate it to 255 for out_pixel.
REQ-019 frame_done SHALL pulse high in the same cycle as the output for centre (H-2,W-2), and SHALL stay low otherwise.
REQ-020 out_pixel SHALL hold its last value while out_valid=0.
REQ-021 The line buffers SHALL NOT be cleared between frames; stale content is never used, because rows 0-1 produce no output.

Reset
REQ-022 rstn low SHALL asynchronously force out_valid=0, out_pixel=0, frame_done=0, col=0, row=0, state=FILL and window registers=0; line-buffer storage SHALL NOT be reset.
REQ-023 After reset is released mid-frame, the next accepted pixel SHALL be treated as pixel (0,0) of a new frame, and no frame_done SHALL be issued for the partial frame.

Configuration
REQ-024 With macro SOBEL_THRESH_EN defined, out_pixel SHALL be 255 when magnitude>=THRESH and 0 otherwise; without the macro, out_pixel SHALL be the saturated magnitude and THRESH SHALL be unused.

Structure
REQ-025 Package sobel_pkg SHALL hold PIX_W=8, GRAD_W=11, MAG_W=11, the kernel weights and the saturate-to-8-bit function.
REQ-026 The line buffer SHALL be a sub-module gray_line_buffer (depth W, 8-bit, one write and one read per accepted pixel, read-before-write at the same address); gray_sobel SHALL instantiate it twice.

Verification
REQ-027 The bench SHALL cover: W=8, H=6, all pixels 128, continuous in_valid -> exactly 24 outputs all 0, frame_done on the 24th only.
REQ-028 The bench SHALL cover: W=8, H=6, cols 0-3 = 0, cols 4-7 = 255 -> outputs for centre cols 3,4 = 255 (Gx=1020 saturated), all other outputs 0.
REQ-029 The bench SHALL cover: W=8, H=6, pixel = col*10 -> all 24 outputs = 80 (Gx=80, Gy=0), out_valid latency exactly 1 cycle after each qualifying input.
REQ-030 The bench SHALL cover: the REQ-029 image with random in_valid gaps -> identical 24-value output sequence, and out_valid never high except in the cycle after an accepted qualifying pixel.
REQ-031 The bench SHALL cover: rstn pulsed after 20 pixels, then a full REQ-029 frame -> all outputs 0 during reset, then exactly 24 outputs = 80 and one frame_done.
REQ-032 The bench SHALL cover: SOBEL_THRESH_EN, THRESH=100, pixel = col*10 -> all outputs 0; pixel = col*30 -> all outputs 255 (magnitude 240).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the gray_sobel edge detector.
//   PIX_W  : grayscale pixel width
//   GRAD_W : signed gradient width (|G| <= 1020, so no overflow)
//   MAG_W  : unsigned magnitude width (|Gx|+|Gy| <= 2040)
//   K_EDGE / K_MID : Sobel kernel weights for the outer and middle taps
//   sobel_state_e  : FILL while the first two rows load, RUN afterwards
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 11;

  localparam logic signed [GRAD_W-1:0] K_EDGE = GRAD_W'(1);
  localparam logic signed [GRAD_W-1:0] K_MID  = GRAD_W'(2);

  typedef enum logic {
    S_FILL,
    S_RUN
  } sobel_state_e;

  // Zero-extend a pixel into the signed gradient domain.
  function automatic logic signed [GRAD_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic [MAG_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? MAG_W'(-g) : MAG_W'(g);
  endfunction

  function automatic logic [PIX_W-1:0] sat8(input logic [MAG_W-1:0] m);
    return (|m[MAG_W-1:PIX_W]) ? '1 : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One image row of grayscale pixels.
//   clk     : write clock
//   we      : write enable (one accepted pixel)
//   addr    : column address, shared by read and write
//   wr_data : pixel written at addr on the clock edge
//   rd_data : pixel currently stored at addr (old value when we=1,
//             i.e. read-before-write)
// Storage is deliberately not reset.
module gray_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 317,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge detector on a raster-order grayscale image.
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : in_pixel is accepted this cycle (no backpressure)
//   in_pixel   : 8-bit grayscale pixel, row-major
//   out_valid  : out_pixel carries a result for an interior pixel
//   out_pixel  : |Gx|+|Gy| saturated to 255, or 0/255 threshold result
//   frame_done : pulses with the last output of a frame
// Optional feature: define SOBEL_THRESH_EN to output 255 when
// magnitude >= THRESH and 0 otherwise.
module gray_sobel
  import sobel_pkg::*;
#(
  parameter int W      = 317,
  parameter int H      = 391,
  parameter int THRESH = 100
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             frame_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  sobel_state_e  state, state_nxt;

  logic [PIX_W-1:0] lb1_rd;   // row r-1 at this column
  logic [PIX_W-1:0] lb2_rd;   // row r-2 at this column

  // Two registered columns: wa = window column 0 (oldest), wb = column 1.
  // The newest column is combinational from the line buffers and in_pixel,
  // so the result can be registered one cycle after acceptance.
  logic [PIX_W-1:0] wa [3];
  logic [PIX_W-1:0] wb [3];
  logic [PIX_W-1:0] nc [3];

  logic signed [GRAD_W-1:0] gx, gy;
  logic [MAG_W-1:0]         mag;
  logic [PIX_W-1:0]         pix_res;
  logic                     col_last, row_last, emit;

  gray_line_buffer #(.DEPTH(W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (col),
    .wr_data (in_pixel),
    .rd_data (lb1_rd)
  );

  // Row r-1 shifts into the r-2 buffer as it is read out.
  gray_line_buffer #(.DEPTH(W), .AW(CW)) u_lb2 (
    .clk     (clk),
    .we      (in_valid),
    .addr    (col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  always_comb begin
    nc[0] = lb2_rd;
    nc[1] = lb1_rd;
    nc[2] = in_pixel;
  end

  always_comb begin
    gx = (K_EDGE * pix_ext(nc[0]) + K_MID * pix_ext(nc[1]) + K_EDGE * pix_ext(nc[2]))
       - (K_EDGE * pix_ext(wa[0]) + K_MID * pix_ext(wa[1]) + K_EDGE * pix_ext(wa[2]));
    gy = (K_EDGE * pix_ext(wa[2]) + K_MID * pix_ext(wb[2]) + K_EDGE * pix_ext(nc[2]))
       - (K_EDGE * pix_ext(wa[0]) + K_MID * pix_ext(wb[0]) + K_EDGE * pix_ext(nc[0]));
    mag = grad_abs(gx) + grad_abs(gy);
`ifdef SOBEL_THRESH_EN
    pix_res = (mag >= MAG_W'(THRESH)) ? '1 : '0;
`else
    pix_res = sat8(mag);
`endif
  end

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign emit     = in_valid && (state == S_RUN) && (col >= CW'(2));

  always_comb begin
    state_nxt = state;
    if (in_valid && col_last) begin
      case (state)
        S_FILL:  if (row == RW'(1)) state_nxt = S_RUN;
        S_RUN:   if (row_last)      state_nxt = S_FILL;
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_FILL;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        wa[i] <= '0;
        wb[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      out_valid  <= emit;
      frame_done <= emit && row_last && col_last;
      if (emit) out_pixel <= pix_res;
      if (in_valid) begin
        for (int unsigned i = 0; i < 3; i++) begin
          wa[i] <= wb[i];
          wb[i] <= nc[i];
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_sobel.sv
module tb_gray_sobel;

  localparam int TW = 8;
  localparam int TH = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       out_valid;
  logic [7:0] out_pixel;
  logic       frame_done;

  gray_sobel #(.W(TW), .H(TH), .THRESH(100)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int img [TH][TW];
  int b_row = 0, b_col = 0;
  int exp_v = 0, exp_fd = 0, exp_pix = 0;
  int n_out = 0, n_fd = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference result for an interior centre pixel (r,c) of img.
  function automatic int ref_pix(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    m = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESH_EN
    return (m >= 100) ? 255 : 0;
`else
    return (m > 255) ? 255 : m;
`endif
  endfunction

  // pat: 0 flat 128, 1 vertical step, 2 col*10, 3 col*30, 4 random
  task automatic load_img(input int pat);
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        case (pat)
          0: img[r][c] = 128;
          1: img[r][c] = (c < 4) ? 0 : 255;
          2: img[r][c] = c * 10;
          3: img[r][c] = c * 30;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // Check the outputs caused by the previous cycle's drive, then drive.
  task automatic step(input logic v, input logic [7:0] px);
    @(negedge clk);
    check("out_valid", int'(out_valid), exp_v);
    check("frame_done", int'(frame_done), exp_fd);
    check("out_pixel", int'(out_pixel), exp_pix);
    if (out_valid) n_out++;
    if (frame_done) n_fd++;
    in_valid = v;
    in_pixel = px;
    exp_v  = 0;
    exp_fd = 0;
    if (v) begin
      if (b_row >= 2 && b_col >= 2) begin
        exp_v   = 1;
        exp_pix = ref_pix(b_row - 1, b_col - 1);
        exp_fd  = (b_row == TH-1 && b_col == TW-1) ? 1 : 0;
      end
      if (b_col == TW-1) begin
        b_col = 0;
        b_row = (b_row == TH-1) ? 0 : b_row + 1;
      end else begin
        b_col++;
      end
    end
  endtask

  task automatic run_frame(input int gap_max);
    n_out = 0;
    n_fd  = 0;
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++) begin
        if (gap_max > 0)
          repeat ($urandom_range(0, gap_max)) step(1'b0, 8'($urandom));
        step(1'b1, 8'(img[r][c]));
      end
    step(1'b0, 8'h00);
    check("frame_outputs", n_out, (TH-2)*(TW-2));
    check("frame_done_count", n_fd, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    load_img(0); run_frame(0);
    load_img(1); run_frame(0);
    load_img(2); run_frame(0);
    load_img(2); run_frame(3);
    load_img(4); run_frame(0);
    load_img(4); run_frame(2);

    // Reset in the middle of a frame: 20 pixels reach row 2, col 3.
    load_img(2);
    n_out = 0;
    n_fd  = 0;
    for (int k = 0; k < 20; k++) step(1'b1, 8'(img[k / TW][k % TW]));
    @(negedge clk);
    check("pre_reset_valid", int'(out_valid), exp_v);
    check("pre_reset_pixel", int'(out_pixel), exp_pix);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(negedge clk);
    check("rst_hold_valid", int'(out_valid), 0);
    check("rst_hold_pixel", int'(out_pixel), 0);
    rstn  = 1'b1;
    b_row = 0;
    b_col = 0;
    exp_v = 0; exp_fd = 0; exp_pix = 0;
    run_frame(0);

    load_img(3); run_frame(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
